// File: rtl/lsu_initiator.sv
// Initiator side of the CPU data-memory interface: accepts one load/store request,
// sequences SETUP -> STROBE -> HOLD on the shared addr/data bus and returns a sized response.
module lsu_initiator #(
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned MEM_BYTES     = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_err,
    output logic [31:0] mem_addr,
    output logic        mem_addr_en,
    output logic [31:0] mem_wdata,
    output logic        mem_wdata_en,
    input  logic [31:0] mem_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_size
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        st_q, st_nx;
    logic [31:0] rdata_q;
    logic        accept;

    logic [3:0]  dec_size;
    logic [2:0]  dec_nbytes;
    logic        dec_legal, dec_misaligned, dec_range;
    logic [1:0]  dec_err;

    logic        req_ready_d, rsp_valid_d, mem_addr_en_d, mem_wdata_en_d, mem_read_d, mem_write_d;
    logic [31:0] rsp_data_d, mem_addr_d, mem_wdata_d;
    logic [1:0]  rsp_err_d;
    logic [3:0]  mem_size_d;
    logic        drive_nx;

    assign accept = req_valid && req_ready;

    // funct3 decode and error classification; 33-bit sum so the range check cannot wrap
    always_comb begin
        dec_size   = '0;
        dec_nbytes = 3'd4;
        dec_legal  = 1'b1;
        case (req_funct3)
            3'b000:  begin dec_size = 4'b1000; dec_nbytes = 3'd1; end
            3'b001:  begin dec_size = 4'b0010; dec_nbytes = 3'd2; end
            3'b010:  begin dec_size = 4'b0000; dec_nbytes = 3'd4; end
            3'b100:  begin dec_size = 4'b0100; dec_nbytes = 3'd1; dec_legal = !req_store; end
            3'b101:  begin dec_size = 4'b0001; dec_nbytes = 3'd2; dec_legal = !req_store; end
            default: dec_legal = 1'b0;
        endcase
        dec_misaligned = ((dec_nbytes == 3'd2) && req_addr[0]) ||
                         ((dec_nbytes == 3'd4) && (req_addr[1:0] != 2'b00));
        dec_range = ({1'b0, req_addr} + 33'(dec_nbytes)) > 33'(MEM_BYTES);
        if (!dec_legal)          dec_err = 2'b11;
        else if (dec_misaligned) dec_err = 2'b01;
        else if (dec_range)      dec_err = 2'b10;
        else                     dec_err = 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (dec_err == 2'b00) ? SETUP : RESP;
            SETUP:   state_nx = STROBE;
            STROBE:  if (cnt == 4'd0) state_nx = HOLD;
            HOLD:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered, so each one is
    // valid for exactly the cycle its state is occupied.
    always_comb begin
        st_nx          = accept ? req_store : st_q;
        drive_nx       = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
        req_ready_d    = (state_nx == IDLE);
        rsp_valid_d    = (state_nx == RESP);
        mem_addr_en_d  = drive_nx;
        mem_wdata_en_d = drive_nx && st_nx;
        mem_read_d     = (state_nx == STROBE) && !st_nx;
        mem_write_d    = (state_nx == STROBE) && st_nx;
        mem_addr_d     = mem_addr;
        mem_wdata_d    = mem_wdata;
        mem_size_d     = mem_size;
        rsp_data_d     = rsp_data;
        rsp_err_d      = rsp_err;
        if (accept) begin
            mem_size_d = dec_size;
            if (dec_err == 2'b00) begin
                mem_addr_d  = req_addr;
                mem_wdata_d = req_wdata;
            end
        end
        if (state_nx == RESP) begin
            rsp_err_d  = accept ? dec_err : 2'b00;
            rsp_data_d = (accept || st_q) ? '0 : rdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            st_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            st_q <= st_nx;
            if (state == SETUP)
                cnt <= 4'(STROBE_CYCLES - 1);
            else if (state == STROBE && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            if (state == STROBE && cnt == 4'd0 && !st_q)
                rdata_q <= mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= '0;
            mem_addr     <= '0;
            mem_addr_en  <= 1'b0;
            mem_wdata    <= '0;
            mem_wdata_en <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_size     <= '0;
        end else begin
            req_ready    <= req_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_data     <= rsp_data_d;
            rsp_err      <= rsp_err_d;
            mem_addr     <= mem_addr_d;
            mem_addr_en  <= mem_addr_en_d;
            mem_wdata    <= mem_wdata_d;
            mem_wdata_en <= mem_wdata_en_d;
            mem_read     <= mem_read_d;
            mem_write    <= mem_write_d;
            mem_size     <= mem_size_d;
        end
    end

endmodule

// File: tb/tb_lsu_initiator.sv
// Directed bench for lsu_initiator: byte-array memory model, response scoreboard queue,
// immediate-assertion checks; second instance covers a multi-cycle strobe.
module tb_lsu_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, mem_addr_en, mem_wdata_en, mem_read, mem_write;
    logic [31:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  rsp_err;
    logic [3:0]  mem_size;

    logic        r3_valid = 1'b0, r3_store = 1'b0;
    logic [2:0]  r3_funct3 = '0;
    logic [31:0] r3_addr = '0, r3_wdata = '0;
    logic        r3_ready, r3_rsp_valid, r3_addr_en, r3_wdata_en, r3_read, r3_write;
    logic [31:0] r3_rsp_data, r3_mem_addr, r3_mem_wdata;
    logic [1:0]  r3_rsp_err;
    logic [3:0]  r3_size;

    typedef struct { logic [31:0] data; logic [1:0] err; } rsp_t;
    rsp_t exp_q[$];
    int tests = 0;
    int fails = 0;

    logic [7:0]  mem [0:8191];
    logic [12:0] ma;
    logic [31:0] mw;

    always #5 clk = ~clk;

    lsu_initiator #(.STROBE_CYCLES(1), .MEM_BYTES(8192)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_addr_en(mem_addr_en),
        .mem_wdata(mem_wdata), .mem_wdata_en(mem_wdata_en), .mem_rdata(mem_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size));

    lsu_initiator #(.STROBE_CYCLES(3), .MEM_BYTES(8192)) dut3 (
        .clk(clk), .rst(rst), .req_valid(r3_valid), .req_ready(r3_ready),
        .req_store(r3_store), .req_funct3(r3_funct3), .req_addr(r3_addr),
        .req_wdata(r3_wdata), .rsp_valid(r3_rsp_valid), .rsp_data(r3_rsp_data),
        .rsp_err(r3_rsp_err), .mem_addr(r3_mem_addr), .mem_addr_en(r3_addr_en),
        .mem_wdata(r3_mem_wdata), .mem_wdata_en(r3_wdata_en), .mem_rdata(32'h0),
        .mem_read(r3_read), .mem_write(r3_write), .mem_size(r3_size));

    // Memory responder: sizes read data itself, writes only the strobed byte lanes
    always_comb begin
        ma = mem_addr[12:0];
        mw = {mem[ma + 13'd3], mem[ma + 13'd2], mem[ma + 13'd1], mem[ma]};
        case (mem_size)
            4'b1000: mw = {{24{mw[7]}}, mw[7:0]};
            4'b0100: mw = {24'h0, mw[7:0]};
            4'b0010: mw = {{16{mw[15]}}, mw[15:0]};
            4'b0001: mw = {16'h0, mw[15:0]};
            default: ;
        endcase
        mem_rdata = mem_read ? mw : '0;
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[12:0]] <= mem_wdata[7:0];
            if (mem_size == 4'b0010 || mem_size == 4'b0001 || mem_size == 4'b0000)
                mem[mem_addr[12:0] + 13'd1] <= mem_wdata[15:8];
            if (mem_size == 4'b0000) begin
                mem[mem_addr[12:0] + 13'd2] <= mem_wdata[23:16];
                mem[mem_addr[12:0] + 13'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // exp_size 4'hF means mem_size is not checked
    task automatic do_req(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_data, input logic [1:0] exp_err,
                          input int exp_lat, input int exp_strb, input int exp_wen,
                          input logic [3:0] exp_size);
        int g, lat, strb, wen;
        logic [3:0] sz;
        rsp_t r;
        g = 0;
        while (!req_ready && g < 20) begin @(negedge clk); g++; end
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        exp_q.push_back('{data: exp_data, err: exp_err});
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_store = ~st; req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1; sz = mem_size;
        strb = int'(mem_read) + int'(mem_write); wen = int'(mem_wdata_en);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk); lat++;
            strb += int'(mem_read) + int'(mem_write); wen += int'(mem_wdata_en);
        end
        r = exp_q.pop_front();
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " rsp_data"}, rsp_data, r.data);
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(r.err));
        chk({tag, " strobes"}, 32'(strb), 32'(exp_strb));
        chk({tag, " wdata_en"}, 32'(wen), 32'(exp_wen));
        chk({tag, " en@rsp"}, 32'({mem_addr_en, mem_wdata_en}), 32'd0);
        if (exp_size != 4'hF) chk({tag, " size"}, 32'(sz), 32'(exp_size));
        @(negedge clk);
        chk({tag, " pulse"}, 32'(rsp_valid), 32'd0);
        chk({tag, " data hold"}, rsp_data, r.data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, lat, wcnt;
        repeat (3) @(negedge clk);
        chk("reset outputs", 32'({req_ready, rsp_valid, mem_addr_en, mem_wdata_en, mem_read, mem_write}), 32'd0);
        chk("reset rsp_data", rsp_data, 32'd0);
        rst = 1'b0;
        #1 chk("ready before edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("ready after edge", 32'(req_ready), 32'd1);

        do_req("SW100",  1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 2'b00, 4, 1, 3, 4'b0000);
        do_req("LW100",  0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2'b00, 4, 1, 0, 4'b0000);
        do_req("SB101",  1, 3'b000, 32'h101, 32'hAAAAAA80, 32'h0, 2'b00, 4, 1, 3, 4'b1000);
        do_req("LB101",  0, 3'b000, 32'h101, 32'h0, 32'hFFFFFF80, 2'b00, 4, 1, 0, 4'b1000);
        do_req("LBU101", 0, 3'b100, 32'h101, 32'h0, 32'h00000080, 2'b00, 4, 1, 0, 4'b0100);
        do_req("LH102",  0, 3'b001, 32'h102, 32'h0, 32'hFFFFDEAD, 2'b00, 4, 1, 0, 4'b0010);
        do_req("LHU102", 0, 3'b101, 32'h102, 32'h0, 32'h0000DEAD, 2'b00, 4, 1, 0, 4'b0001);

        do_req("SW200",  1, 3'b010, 32'h200, 32'h55667788, 32'h0, 2'b00, 4, 1, 3, 4'b0000);
        do_req("SH200",  1, 3'b001, 32'h200, 32'h1234ABCD, 32'h0, 2'b00, 4, 1, 3, 4'b0010);
        chk("mem200", 32'(mem[13'h200]), 32'hCD);
        chk("mem201", 32'(mem[13'h201]), 32'hAB);
        chk("mem202", 32'(mem[13'h202]), 32'h66);
        chk("mem203", 32'(mem[13'h203]), 32'h55);

        do_req("LH003",   0, 3'b001, 32'h003,  32'h0, 32'h0, 2'b01, 1, 0, 0, 4'hF);
        // a word at 0x1FFE is misaligned, which outranks the range fault
        do_req("SW1FFE",  1, 3'b010, 32'h1FFE, 32'h1, 32'h0, 2'b01, 1, 0, 0, 4'hF);
        do_req("SW2000",  1, 3'b010, 32'h2000, 32'h1, 32'h0, 2'b10, 1, 0, 0, 4'hF);
        do_req("LB2000",  0, 3'b000, 32'h2000, 32'h0, 32'h0, 2'b10, 1, 0, 0, 4'hF);
        do_req("SWhuge",  1, 3'b010, 32'hFFFFFFFC, 32'h1, 32'h0, 2'b10, 1, 0, 0, 4'hF);
        do_req("S100",    1, 3'b100, 32'h000,  32'h1, 32'h0, 2'b11, 1, 0, 0, 4'hF);
        do_req("L011",    0, 3'b011, 32'h000,  32'h0, 32'h0, 2'b11, 1, 0, 0, 4'hF);
        do_req("S101mis", 1, 3'b101, 32'h001,  32'h1, 32'h0, 2'b11, 1, 0, 0, 4'hF);
        do_req("LH1FFF",  0, 3'b001, 32'h1FFF, 32'h0, 32'h0, 2'b01, 1, 0, 0, 4'hF);
        do_req("SW1FFC",  1, 3'b010, 32'h1FFC, 32'h01020304, 32'h0, 2'b00, 4, 1, 3, 4'b0000);
        do_req("LW1FFC",  0, 3'b010, 32'h1FFC, 32'h0, 32'h01020304, 2'b00, 4, 1, 0, 4'b0000);
        do_req("LBU1FFF", 0, 3'b100, 32'h1FFF, 32'h0, 32'h00000001, 2'b00, 4, 1, 0, 4'b0100);

        // abort a store mid-strobe with an asynchronous reset
        do_req("SW300",  1, 3'b010, 32'h300, 32'h11111111, 32'h0, 2'b00, 4, 1, 3, 4'b0000);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        g = 0;
        while (!mem_write && g < 10) begin @(negedge clk); g++; end
        chk("abort reached strobe", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1 chk("abort strobes/enables", 32'({mem_write, mem_read, mem_addr_en, mem_wdata_en}), 32'd0);
        g = 0;
        repeat (4) begin @(negedge clk); g += int'(rsp_valid); end
        chk("abort no rsp", 32'(g), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort mem untouched", {mem[13'h303], mem[13'h302], mem[13'h301], mem[13'h300]}, 32'h11111111);
        do_req("LW300",  0, 3'b010, 32'h300, 32'h0, 32'h11111111, 2'b00, 4, 1, 0, 4'b0000);

        // three-cycle strobe instance
        g = 0;
        while (!r3_ready && g < 20) begin @(negedge clk); g++; end
        chk("S3 ready", 32'(r3_ready), 32'd1);
        exp_q.push_back('{data: 32'h0, err: 2'b00});
        r3_valid = 1'b1; r3_store = 1'b1; r3_funct3 = 3'b010; r3_addr = 32'h10; r3_wdata = 32'h0BADC0DE;
        @(posedge clk);
        @(negedge clk);
        r3_valid = 1'b0;
        lat = 1; wcnt = int'(r3_write);
        while (!r3_rsp_valid && lat < 40) begin
            @(negedge clk); lat++; wcnt += int'(r3_write);
        end
        begin
            rsp_t r;
            r = exp_q.pop_front();
            chk("S3 latency", 32'(lat), 32'd6);
            chk("S3 write cycles", 32'(wcnt), 32'd3);
            chk("S3 rsp_err", 32'(r3_rsp_err), 32'(r.err));
            chk("S3 rsp_data", r3_rsp_data, r.data);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
